// File: rtl/arduino_link_pkg.sv
// Shared constants and TX state encoding for the FPGA<->Arduino UART link.
// Used by both the outbound frame sender and the inbound angle receiver.
package arduino_link_pkg;

  localparam logic [7:0] DEFAULT_HEADER       = 8'hA5;
  localparam int         DEFAULT_CLKS_PER_BIT = 10416;  // 100 MHz / 9600 baud

  localparam int FRAME_BYTES          = 3;  // header, low, high
  localparam int FRAME_BYTES_CHECKSUM = 4;  // header, low, high, low^high

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer; start bit on the cycle after start, line registered.
// Takes a new byte only while idle or on the last stop-bit cycle (byteDone), giving gapless bytes.
module uart_tx_byte
  import arduino_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byteIn,
  output logic       idle,
  output logic       byteDone,
  output logic       txLine
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  txState_t      state, stateNext;
  logic [CW-1:0] bitCnt, bitCntNext;
  logic [2:0]    bitIdx, bitIdxNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          lineNext;
  logic          bitEnd;

  assign bitEnd   = (bitCnt == LAST);
  assign idle     = (state == IDLE);
  assign byteDone = (state == STOP) && bitEnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bitCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txLine   <= 1'b1;
    end else begin
      state    <= stateNext;
      bitCnt   <= bitCntNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftNext;
      txLine   <= lineNext;
    end
  end

  always_comb begin
    stateNext  = state;
    bitCntNext = bitEnd ? '0 : bitCnt + 1'b1;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    lineNext   = txLine;
    case (state)
      IDLE: begin
        bitCntNext = '0;
        lineNext   = 1'b1;
        if (start) begin
          stateNext = START;
          shiftNext = byteIn;
          lineNext  = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext  = DATA;
          bitIdxNext = '0;
          lineNext   = shiftReg[0];
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            lineNext  = 1'b1;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
            shiftNext  = shiftReg >> 1;
            lineNext   = shiftReg[1];
          end
        end
      end
      STOP: begin
        // Chaining straight into the next start bit keeps bytes contiguous.
        if (bitEnd) begin
          if (start) begin
            stateNext = START;
            shiftNext = byteIn;
            lineNext  = 1'b0;
          end else begin
            stateNext = IDLE;
            lineNext  = 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        lineNext  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/send_to_arduino.sv
// Frames a 16-bit word as HEADER, low, high (+ low^high with SEND_TO_ARDUINO_CHECKSUM_EN) over UART 8N1.
// Start bit one cycle after accept; ready is low for the whole frame and words offered while busy are dropped.
module send_to_arduino
  import arduino_link_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [7:0] HEADER       = DEFAULT_HEADER,
  parameter int         SIZE         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] data,
  input  logic            dataValid,
  output logic            ready,
  output logic            serialToArduino
);

`ifdef SEND_TO_ARDUINO_CHECKSUM_EN
  localparam int NBYTES = FRAME_BYTES_CHECKSUM;
`else
  localparam int NBYTES = FRAME_BYTES;
`endif
  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

  logic [SIZE-1:0] word;
  logic [1:0]      byteIdx;
  logic            accept;
  logic            txIdle;
  logic            byteDone;
  logic            txStart;
  logic [7:0]      txByte;

  function automatic logic [7:0] frameByte(input logic [1:0] idx, input logic [SIZE-1:0] w);
    case (idx)
      2'd0:    return HEADER;
      2'd1:    return w[7:0];
      2'd2:    return w[15:8];
`ifdef SEND_TO_ARDUINO_CHECKSUM_EN
      default: return w[7:0] ^ w[15:8];
`else
      default: return HEADER;
`endif
    endcase
  endfunction

  // The serializer only idles between frames, so its idle flag is the ready.
  assign ready  = txIdle;
  assign accept = dataValid && ready;

  always_comb begin
    txStart = 1'b0;
    txByte  = HEADER;
    if (accept) begin
      txStart = 1'b1;
    end else if (byteDone && (byteIdx != LAST_IDX)) begin
      txStart = 1'b1;
      txByte  = frameByte(byteIdx + 2'd1, word);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word    <= '0;
      byteIdx <= '0;
    end else if (accept) begin
      word    <= data;
      byteIdx <= '0;
    end else if (byteDone) begin
      byteIdx <= (byteIdx == LAST_IDX) ? 2'd0 : byteIdx + 2'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTx (
    .clk     (clk),
    .rst     (rst),
    .start   (txStart),
    .byteIn  (txByte),
    .idle    (txIdle),
    .byteDone(byteDone),
    .txLine  (serialToArduino)
  );

endmodule

// File: tb/tb_send_to_arduino.sv
// Directed + random frames decoded from the serial line at mid-bit and compared to a byte-list frame model.
module tb_send_to_arduino;

  localparam int BIT = 4;
`ifdef SEND_TO_ARDUINO_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic        dataValid = 1'b0;
  logic        ready;
  logic        serialToArduino;

  int passCnt = 0;
  int failCnt = 0;
  int totalCnt = 0;

  int   highRun = 0;
  int   lastHighRun = 0;
  int   fallCnt = 0;
  logic prevLine = 1'b1;

  always #5 clk = ~clk;

  send_to_arduino #(
    .CLKS_PER_BIT(BIT),
    .HEADER      (8'hA5),
    .SIZE        (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data           (data),
    .dataValid      (dataValid),
    .ready          (ready),
    .serialToArduino(serialToArduino)
  );

  // Line monitor: length of the most recent high run and number of falling edges.
  always @(negedge clk) begin
    if (serialToArduino === 1'b1) begin
      highRun <= highRun + 1;
    end else begin
      if (prevLine === 1'b1) begin
        lastHighRun <= highRun;
        fallCnt     <= fallCnt + 1;
      end
      highRun <= 0;
    end
    prevLine <= serialToArduino;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame model: the byte list a word must produce on the wire.
  function automatic logic [7:0] expByte(input logic [15:0] w, input int i);
    logic [7:0] frame [4];
    frame[0] = 8'hA5;
    frame[1] = w[7:0];
    frame[2] = w[15:8];
    frame[3] = w[7:0] ^ w[15:8];
    return frame[i];
  endfunction

  // Offer a word once ready is seen; returns at the first cycle after the accept.
  task automatic offer(input logic [15:0] w, input bit hold);
    int n = 0;
    while (ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("offerReady", {15'd0, ready}, 16'd1);
    data      = w;
    dataValid = 1'b1;
    @(negedge clk);
    if (!hold) dataValid = 1'b0;
  endtask

  // Called at frame offset 0 (first cycle of the first start bit); returns at offset NB*4*10.
  task automatic recvFrame(input logic [15:0] w, input string tag);
    logic [7:0] got;
    for (int k = 0; k < NB; k++) begin
      check($sformatf("%s.startEdge%0d", tag, k), {15'd0, serialToArduino}, 16'd0);
      check($sformatf("%s.busy%0d", tag, k), {15'd0, ready}, 16'd0);
      repeat (BIT / 2) @(negedge clk);
      check($sformatf("%s.startMid%0d", tag, k), {15'd0, serialToArduino}, 16'd0);
      for (int b = 0; b < 8; b++) begin
        repeat (BIT) @(negedge clk);
        got[b] = serialToArduino;
      end
      check($sformatf("%s.byte%0d", tag, k), {8'd0, got}, {8'd0, expByte(w, k)});
      repeat (BIT) @(negedge clk);
      check($sformatf("%s.stop%0d", tag, k), {15'd0, serialToArduino}, 16'd1);
      if (k == NB - 1) begin
        @(negedge clk);
        check($sformatf("%s.lastStopBusy", tag), {15'd0, ready}, 16'd0);
        @(negedge clk);
        check($sformatf("%s.readyBack", tag), {15'd0, ready}, 16'd1);
      end else begin
        repeat (BIT / 2) @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [15:0] w;
    int          fc;

    // Reset held 5 cycles: line high, ready high, no edges.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rstLine", {15'd0, serialToArduino}, 16'd1);
      check("rstReady", {15'd0, ready}, 16'd1);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("postRstLine", {15'd0, serialToArduino}, 16'd1);
    check("postRstReady", {15'd0, ready}, 16'd1);
    check("rstNoEdges", fallCnt[15:0], 16'd0);

    // Single word.
    offer(16'h00B4, 1'b0);
    recvFrame(16'h00B4, "single");

    // Back-to-back with dataValid held high.
    repeat (3) @(negedge clk);
    offer(16'h0123, 1'b1);
    data = 16'hFF80;
    recvFrame(16'h0123, "b2bA");
    @(negedge clk);
    dataValid = 1'b0;
    #1;
    check("b2bGap", lastHighRun[15:0], 16'd5);
    recvFrame(16'hFF80, "b2bB");

    // Word offered mid-frame is dropped.
    repeat (4) @(negedge clk);
    offer(16'h1111, 1'b0);
    fork
      recvFrame(16'h1111, "busyIgn");
      begin
        repeat (10) @(negedge clk);
        data      = 16'hFFFF;
        dataValid = 1'b1;
        @(negedge clk);
        dataValid = 1'b0;
      end
    join
    fc = fallCnt;
    repeat (60) @(negedge clk);
    check("busyNoSecond", fallCnt[15:0], fc[15:0]);

    // Reset during the low byte's data bit 3 (frame offset 57).
    w = 16'($urandom) & 16'hFFF7;
    offer(w, 1'b0);
    repeat (57) @(negedge clk);
    check("midRstBitLow", {15'd0, serialToArduino}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midRstLine", {15'd0, serialToArduino}, 16'd1);
    check("midRstReady", {15'd0, ready}, 16'd1);
    rst = 1'b0;
    fc = fallCnt;
    repeat (8) @(negedge clk);
    #1;
    check("midRstQuiet", fallCnt[15:0], fc[15:0]);
    offer(16'h5A5A, 1'b0);
    recvFrame(16'h5A5A, "afterRst");

    // Random words with random idle gaps (gap 0 exercises immediate re-accept).
    for (int r = 0; r < 6; r++) begin
      w = 16'($urandom);
      repeat ($urandom_range(0, 7)) @(negedge clk);
      offer(w, 1'b0);
      recvFrame(w, $sformatf("rand%0d", r));
    end

`ifdef SEND_TO_ARDUINO_CHECKSUM_EN
    repeat (3) @(negedge clk);
    offer(16'h1234, 1'b0);
    recvFrame(16'h1234, "checksum");
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/send_to_arduino.md
Name: send_to_arduino

Overview:
- UART 8N1 transmitter for the FPGA-to-Arduino link, the outbound counterpart of the Arduino angle receiver.
- Accepts a 16-bit telemetry word (e.g. motorPower or latest angle) through a valid/ready handshake.
- Serializes it as a framed packet on one output line: header byte, low byte, high byte.
- Lets the Arduino log or act on controller state without extra wiring.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per serial bit (100 MHz / 9600 baud); must be >= 2.
- HEADER, 8'hA5, sync byte sent first in every frame.
- SIZE, 16, payload width; fixed at 16, other values unsupported.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- data  input  SIZE  word to transmit; sampled only on the accept cycle.
- dataValid  input  1  producer has a word.
- ready  output  1  block can accept a word this cycle.
- serialToArduino  output  1  UART TX line, idle high.

Behaviour:
- Reset values: serialToArduino=1, ready=1, FSM=IDLE, bit counter=0, byte index=0, latched word=0.
- Reset takes effect at the next clk edge, including mid-frame. The line returns high immediately; no partial byte is completed.
- Handshake: a word is accepted in cycle N when dataValid=1 and ready=1 are both true in that cycle. data is latched at that edge, and ready=0 from cycle N+1.
- dataValid and data are ignored while ready=0. No queuing; a word offered while busy is lost unless it is held.
- Latency: the start bit (line=0) begins in cycle N+1.
- Frame byte order: HEADER, data[7:0], data[15:8].
- Each byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Bytes within a frame are contiguous: the next start bit follows the previous stop bit with no gap.
- Frame length: 30*CLKS_PER_BIT cycles, or 40*CLKS_PER_BIT with checksum.
- FSM states: IDLE -> START -> DATA (8 bits) -> STOP.
  - From STOP: go to START if more bytes remain in the frame, else go to IDLE.
  - In IDLE: ready=1 and line=1.
  - After the final stop bit's last cycle T, ready=1 in cycle T+1.
- Back-to-back frames: if dataValid is already high at T+1, the word is accepted at T+1 and the start bit begins at T+2. The line therefore stays high for CLKS_PER_BIT+1 cycles between frames.
- Bit counter: counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances to the next bit. Width is $clog2(CLKS_PER_BIT).
- Output serialToArduino is registered (glitch-free).

Optional Feature:
- Macro: SEND_TO_ARDUINO_CHECKSUM_EN.
- Defined: a fourth byte is sent after the high byte, equal to data[7:0] XOR data[15:8]. The frame is 40 bit times.
- Undefined: frames are 3 bytes and no checksum logic is built.

Decomposition:
- Shared package, arduino_link_pkg:
  - HEADER default constant.
  - Default CLKS_PER_BIT value.
  - FSM state encoding.
  - Frame byte-count constants (3, and 4 with checksum).
  - The receiver will reuse the same package.
- Sub-module uart_tx_byte:
  - Single-byte 8N1 serializer with its own start/busy handshake and bit counter.
  - Top level is the frame sequencer that selects the byte to send and drives uart_tx_byte.

Test Plan (bench uses CLKS_PER_BIT=4, sampling each bit at mid-bit):
- Reset: hold rst for 5 cycles -> serialToArduino=1 and ready=1 throughout and after release; no edges on the line.
- Single word: data=16'h00B4 pulsed with dataValid for 1 cycle -> bytes A5, B4, 00 decoded. Start bit begins 1 cycle after accept. ready returns 1 exactly 120 cycles after the start bit begins.
- Back-to-back: dataValid held high with 16'h0123 then 16'hFF80 -> frames A5,23,01 then A5,80,FF. The line stays high exactly 5 cycles between frames.
- Busy ignore: accept 16'h1111, then pulse dataValid with 16'hFFFF at cycle 10 of the frame -> only A5,11,11 is transmitted; no second frame.
- Reset mid-frame: assert rst during the low byte's bit 3 -> line=1 and ready=1 the next cycle. A following word 16'h5A5A is sent intact as A5,5A,5A.
- Checksum (SEND_TO_ARDUINO_CHECKSUM_EN defined): 16'h1234 -> bytes A5,34,12,26. The frame lasts 160 cycles.
